// File: rtl/rb_sys_bus_master.sv
// RadioBox system-bus initiator: buffers register commands in a FIFO and
// runs them one at a time over the sys_* handshake, returning one response each.
module rb_sys_bus_master #(
    parameter int unsigned FIFO_AW    = 2,
    parameter int unsigned TMO_CYCLES = 16
) (
    input  logic        clk_adc_125mhz,
    input  logic        adc_rst_i,

    input  logic        cmd_vld,
    output logic        cmd_rdy,
    input  logic        cmd_we,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_sel,

    output logic        rsp_vld,
    input  logic        rsp_rdy,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_tmo,

    output logic [31:0] sys_addr,
    output logic [31:0] sys_wdata,
    output logic [3:0]  sys_sel,
    output logic        sys_wen,
    output logic        sys_ren,
    input  logic [31:0] sys_rdata,
    input  logic        sys_err,
    input  logic        sys_ack,

    output logic        busy
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CNT_W = FIFO_AW + 1;
    localparam int unsigned CW    = $clog2(TMO_CYCLES + 1);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CW-1:0]    TMO_LAST = CW'(TMO_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
    } cmd_t;

    cmd_t               mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full, empty, push, pop;
    cmd_t               head;

    state_t             state_q, state_d;
    logic [CW-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic               we_q, we_d;
    logic [31:0]        sys_addr_q, sys_addr_d;
    logic [31:0]        sys_wdata_q, sys_wdata_d;
    logic [3:0]         sys_sel_q, sys_sel_d;
    logic               sys_wen_q, sys_wen_d;
    logic               sys_ren_q, sys_ren_d;
    logic               rsp_vld_q, rsp_vld_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;
    logic               rsp_tmo_q, rsp_tmo_d;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign cmd_rdy = !full && !adc_rst_i;
    assign push    = cmd_vld && cmd_rdy;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset: flushing the pointers and count empties the FIFO.
    always_ff @(posedge clk_adc_125mhz) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_t'{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata, sel: cmd_sel};
        end
    end

    always_comb begin
        state_d     = state_q;
        tmo_cnt_d   = tmo_cnt_q;
        we_d        = we_q;
        sys_addr_d  = sys_addr_q;
        sys_wdata_d = sys_wdata_q;
        sys_sel_d   = sys_sel_q;
        sys_wen_d   = 1'b0;
        sys_ren_d   = 1'b0;
        rsp_vld_d   = rsp_vld_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_tmo_d   = rsp_tmo_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop         = 1'b1;
                    we_d        = head.we;
                    sys_addr_d  = head.addr;
                    sys_wdata_d = head.wdata;
                    sys_sel_d   = head.sel;
                    // Strobes are registered, so they are set on entry to ISSUE.
                    sys_wen_d   = head.we;
                    sys_ren_d   = !head.we;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                tmo_cnt_d = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (sys_ack) begin
                    rsp_vld_d   = 1'b1;
                    rsp_rdata_d = we_q ? '0 : sys_rdata;
                    rsp_err_d   = sys_err;
                    rsp_tmo_d   = 1'b0;
                    state_d     = RESP;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    rsp_vld_d   = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_tmo_d   = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_rdy) begin
                    rsp_vld_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_adc_125mhz) begin
        if (adc_rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            tmo_cnt_q   <= '0;
            we_q        <= 1'b0;
            sys_addr_q  <= '0;
            sys_wdata_q <= '0;
            sys_sel_q   <= '0;
            sys_wen_q   <= 1'b0;
            sys_ren_q   <= 1'b0;
            rsp_vld_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            tmo_cnt_q   <= tmo_cnt_d;
            we_q        <= we_d;
            sys_addr_q  <= sys_addr_d;
            sys_wdata_q <= sys_wdata_d;
            sys_sel_q   <= sys_sel_d;
            sys_wen_q   <= sys_wen_d;
            sys_ren_q   <= sys_ren_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_tmo_q   <= rsp_tmo_d;
        end
    end

    assign sys_addr  = sys_addr_q;
    assign sys_wdata = sys_wdata_q;
    assign sys_sel   = sys_sel_q;
    assign sys_wen   = sys_wen_q;
    assign sys_ren   = sys_ren_q;
    assign rsp_vld   = rsp_vld_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_tmo   = rsp_tmo_q;
    assign busy      = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_rb_sys_bus_master.sv
// Scoreboard bench for rb_sys_bus_master: stimulus queues expected bus cycles
// and responses, negedge monitors pop and compare them.
module tb_rb_sys_bus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_vld, cmd_rdy, cmd_we;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_sel;
    logic        rsp_vld, rsp_rdy, rsp_err, rsp_tmo;
    logic [31:0] rsp_rdata;
    logic [31:0] sys_addr, sys_wdata, sys_rdata;
    logic [3:0]  sys_sel;
    logic        sys_wen, sys_ren, sys_err, sys_ack, busy;

    logic        slave_ack, inj_ack, slave_ack_en, slave_err;
    logic [31:0] slave_rdata;
    assign sys_ack = slave_ack | inj_ack;

    rb_sys_bus_master #(.FIFO_AW(2), .TMO_CYCLES(16)) dut (
        .clk_adc_125mhz(clk), .adc_rst_i(rst),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_tmo(rsp_tmo),
        .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_sel(sys_sel),
        .sys_wen(sys_wen), .sys_ren(sys_ren), .sys_rdata(sys_rdata),
        .sys_err(sys_err), .sys_ack(sys_ack), .busy(busy)
    );

    always #4 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
    } bus_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } rsp_t;

    bus_t exp_bus[$];
    rsp_t exp_rsp[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rsp_cnt = 0;
    int strobe_cyc = -1;
    int rsp_rise_cyc = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Slave with registered ack: answers in the cycle after the strobe.
    initial begin
        slave_ack = 1'b0;
        sys_rdata = '0;
        sys_err   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if ((sys_wen || sys_ren) && slave_ack_en) begin
                @(posedge clk);
                #1;
                slave_ack = 1'b1;
                sys_rdata = slave_rdata;
                sys_err   = slave_err;
                @(posedge clk);
                #1;
                slave_ack = 1'b0;
                sys_rdata = '0;
                sys_err   = 1'b0;
            end
        end
    end

    // Monitor: bus strobes and response handshakes against the queues.
    initial begin
        logic strobe;
        logic strobe_prev;
        logic vld_prev;
        bus_t b;
        rsp_t r;
        strobe_prev = 1'b0;
        vld_prev    = 1'b0;
        forever begin
            @(negedge clk);
            strobe = sys_wen | sys_ren;
            if (strobe) begin
                chk("strobe_excl", {31'd0, sys_wen & sys_ren}, 32'd0);
                chk("strobe_1cyc", {31'd0, strobe_prev}, 32'd0);
                strobe_cyc = cyc;
                if (exp_bus.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL bus_unexpected: strobe at addr %h, none expected", sys_addr);
                end else begin
                    b = exp_bus.pop_front();
                    chk("bus_wen", {31'd0, sys_wen}, {31'd0, b.we});
                    chk("bus_ren", {31'd0, sys_ren}, {31'd0, !b.we});
                    chk("bus_addr", sys_addr, b.addr);
                    chk("bus_wdata", sys_wdata, b.wdata);
                    chk("bus_sel", {28'd0, sys_sel}, {28'd0, b.sel});
                end
            end
            strobe_prev = strobe;
            if (rsp_vld && !vld_prev) rsp_rise_cyc = cyc;
            vld_prev = rsp_vld;
            if (rsp_vld && rsp_rdy) begin
                rsp_cnt++;
                if (exp_rsp.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_unexpected: rdata %h err %b tmo %b, none expected",
                             rsp_rdata, rsp_err, rsp_tmo);
                end else begin
                    r = exp_rsp.pop_front();
                    chk("rsp_rdata", rsp_rdata, r.rdata);
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, r.err});
                    chk("rsp_tmo", {31'd0, rsp_tmo}, {31'd0, r.tmo});
                end
            end
        end
    end

    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] sel, input logic [31:0] e_rdata, input logic e_err,
                        input logic e_tmo, input int budget, output int c0, output logic ok);
        cmd_vld   = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_sel   = sel;
        ok = 1'b0;
        c0 = -1;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            if (cmd_rdy) begin
                ok = 1'b1;
                c0 = cyc;
                exp_bus.push_back(bus_t'{we: we, addr: addr, wdata: wdata, sel: sel});
                exp_rsp.push_back(rsp_t'{rdata: e_rdata, err: e_err, tmo: e_tmo});
            end
            @(posedge clk);
        end
        #1;
        if (ok) cmd_vld = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input int budget);
        for (int n = 0; n < budget && rsp_cnt < target; n++) @(posedge clk);
        #1;
        chk("rsp_count", rsp_cnt, target);
    endtask

    initial begin
        int   c0;
        int   base;
        int   nacc;
        logic ok;

        rst = 1'b1;
        cmd_vld = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_sel = '0;
        rsp_rdy = 1'b1;
        inj_ack = 1'b0; slave_ack_en = 1'b1; slave_err = 1'b0; slave_rdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_outs", {24'd0, sys_wen, sys_ren, rsp_vld, rsp_err, rsp_tmo, 3'd0}, 32'd0);
        chk("post_rst_addr", sys_addr | sys_wdata | rsp_rdata, 32'd0);
        @(posedge clk);
        #1;

        // Write with prompt ack; read data from slave must not leak into the response.
        slave_rdata = 32'h5555AAAA;
        send(1'b1, 32'h30, 32'h12345678, 4'hF, 32'h0, 1'b0, 1'b0, 10, c0, ok);
        chk("wr_accept", {31'd0, ok}, 32'd1);
        wait_rsp(1, 20);
        chk("wr_strobe_cyc", strobe_cyc, c0 + 2);
        chk("wr_rsp_cyc", rsp_rise_cyc, c0 + 4);

        slave_rdata = 32'hCAFEBABE;
        send(1'b0, 32'h28, 32'h0, 4'hF, 32'hCAFEBABE, 1'b0, 1'b0, 10, c0, ok);
        wait_rsp(2, 20);
        chk("rd_strobe_cyc", strobe_cyc, c0 + 2);
        chk("rd_rsp_cyc", rsp_rise_cyc, c0 + 4);

        // Timeout, then a late ack that must be ignored.
        slave_ack_en = 1'b0;
        send(1'b0, 32'h40, 32'h0, 4'h3, 32'h0, 1'b1, 1'b1, 10, c0, ok);
        wait_rsp(3, 40);
        chk("tmo_latency", rsp_rise_cyc - strobe_cyc, 32'd17);
        @(posedge clk);
        #1 inj_ack = 1'b1;
        @(posedge clk);
        #1 inj_ack = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("late_ack_ignored", rsp_cnt, 3);
        chk("late_ack_busy", {31'd0, busy}, 32'd0);

        // Backpressure: FIFO plus in-flight slot hold five commands.
        slave_ack_en = 1'b1;
        rsp_rdy = 1'b0;
        base = rsp_cnt;
        nacc = 0;
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 32'(i * 4), 32'hA0 + 32'(i), 4'hF, 32'h0, 1'b0, 1'b0, 20, c0, ok);
            if (ok) nacc++;
        end
        chk("bp_accepted", nacc, 5);
        send(1'b1, 32'h14, 32'hA5, 4'hF, 32'h0, 1'b0, 1'b0, 10, c0, ok);
        chk("bp_full_reject", {31'd0, ok}, 32'd0);
        chk("bp_no_rsp", rsp_cnt, base);
        rsp_rdy = 1'b1;
        send(1'b1, 32'h14, 32'hA5, 4'hF, 32'h0, 1'b0, 1'b0, 40, c0, ok);
        chk("bp_late_accept", {31'd0, ok}, 32'd1);
        chk("bp_rdy_after_first", rsp_cnt - base, 32'd1);
        wait_rsp(base + 6, 200);

        // Slave error on a read.
        slave_err = 1'b1;
        slave_rdata = 32'hDEAD0001;
        send(1'b0, 32'h2C, 32'h0, 4'h1, 32'hDEAD0001, 1'b1, 1'b0, 10, c0, ok);
        wait_rsp(base + 7, 20);
        slave_err = 1'b0;

        // Reset while in WAIT with two commands queued.
        slave_ack_en = 1'b0;
        send(1'b0, 32'h50, 32'h0, 4'hF, 32'h0, 1'b1, 1'b1, 10, c0, ok);
        send(1'b0, 32'h54, 32'h0, 4'hF, 32'h0, 1'b1, 1'b1, 10, c0, ok);
        send(1'b1, 32'h58, 32'h77, 4'hF, 32'h0, 1'b0, 1'b0, 10, c0, ok);
        rst = 1'b1;
        @(negedge clk);
        chk("rst2_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_bus.delete();
        exp_rsp.delete();
        base = rsp_cnt;
        @(negedge clk);
        chk("rst2_busy", {31'd0, busy}, 32'd0);
        chk("rst2_cmd_rdy_after", {31'd0, cmd_rdy}, 32'd1);
        chk("rst2_flags", {27'd0, sys_wen, sys_ren, rsp_vld, rsp_err, rsp_tmo}, 32'd0);
        chk("rst2_sys_addr", sys_addr, 32'd0);
        chk("rst2_sys_wdata", sys_wdata, 32'd0);
        chk("rst2_sys_sel", {28'd0, sys_sel}, 32'd0);
        chk("rst2_rsp_rdata", rsp_rdata, 32'd0);
        @(posedge clk);
        #1 inj_ack = 1'b1;
        @(posedge clk);
        #1 inj_ack = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("rst2_no_rsp", rsp_cnt, base);
        chk("rst2_idle", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rb_sys_bus_master.md
# rb_sys_bus_master

System-bus initiator for the RadioBox domain, the requesting side of the `sys_addr`/`sys_wen`/`sys_ren`/`sys_ack` register-bus protocol. It accepts register read/write commands through a valid/ready port and buffers them in a small FIFO. It issues them one at a time to a bus slave, such as the RadioBox register bank, and returns each completion, read data or error, through a valid/ready response port. Typical users: OSC1/OSC2 frequency-hop sequencers and test harnesses that drive RadioBox registers without the PS.

## Interface
Parameters:
- `FIFO_AW`, 2: command FIFO address width; depth = 2^FIFO_AW entries.
- `TMO_CYCLES`, 16: maximum WAIT cycles before a transaction is declared timed out (≥2).

Ports:
- `clk_adc_125mhz`  in  1  sole clock.
- `adc_rst_i`  in  1  reset, synchronous, active-high.
- `cmd_vld`  in  1  command valid.
- `cmd_rdy`  out  1  command ready.
- `cmd_we`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  32  bus address.
- `cmd_wdata`  in  32  write data.
- `cmd_sel`  in  4  byte select.
- `rsp_vld`  out  1  response valid.
- `rsp_rdy`  in  1  response ready.
- `rsp_rdata`  out  32  read data; 0 for writes and for timeouts.
- `rsp_err`  out  1  slave `sys_err` or timeout.
- `rsp_tmo`  out  1  timeout flag.
- `sys_addr`  out  32  bus address.
- `sys_wdata`  out  32  bus write data.
- `sys_sel`  out  4  bus byte select.
- `sys_wen`  out  1  write strobe, one cycle.
- `sys_ren`  out  1  read strobe, one cycle.
- `sys_rdata`  in  32  slave read data.
- `sys_err`  in  1  slave error.
- `sys_ack`  in  1  slave acknowledge.
- `busy`  out  1  FIFO non-empty or FSM not IDLE.

## Operation
- Command FIFO: push on `cmd_vld & cmd_rdy`. `cmd_rdy = !full & !adc_rst_i`. No bypass: a pushed entry is visible to the FSM on the next cycle. Push and pop in the same cycle are legal when the FIFO is not full. Pointers wrap modulo depth; the occupancy counter is FIFO_AW+1 bits.
- FSM states: IDLE, ISSUE, WAIT, RESP. At most one transaction outstanding.
- IDLE: when the FIFO is non-empty, pop the head, register it onto `sys_addr`/`sys_wdata`/`sys_sel`, go to ISSUE.
- ISSUE: exactly one cycle, with `sys_wen = we` and `sys_ren = !we`. Any `sys_ack` in this cycle is ignored. Clear the timeout counter and go to WAIT.
- WAIT: the counter increments each cycle.
  - On `sys_ack`, capture `rsp_rdata` (`sys_rdata` for reads, 0 for writes), set `rsp_err = sys_err` and `rsp_tmo = 0`, go to RESP.
  - If the counter reaches TMO_CYCLES with no ack, set `rsp_rdata = 0`, `rsp_err = 1`, `rsp_tmo = 1`, go to RESP.
- RESP: `rsp_vld = 1`, and the response fields stay stable until `rsp_vld & rsp_rdy`. Then go to IDLE; the next command is popped in that IDLE cycle at the earliest.
- `sys_ack` outside WAIT is ignored. This covers late acks after a timeout and stray acks.
- `sys_addr`/`sys_wdata`/`sys_sel` hold their last issued values between transactions.
- Reset:
  - FIFO is flushed and the FSM goes to IDLE.
  - Outputs `sys_*`, `rsp_*` and `busy` are 0.
  - `cmd_rdy` is 0 while reset is asserted and 1 on the first cycle after.
  - Reset in any state drops the in-flight transaction; no response is produced for it.

## Timing
- C0: command handshake.
- C1: FSM in IDLE, pops the entry.
- C2: ISSUE, strobe high.
- C3: earliest `sys_ack`, given a slave with registered ack.
- C4: `rsp_vld` high.
- Minimum command-to-response latency is 4 cycles. Back-to-back throughput, with `rsp_rdy` tied high and a 1-cycle-ack slave, is one transaction per 4 cycles.
- Timeout: with no ack, `rsp_vld` rises TMO_CYCLES+1 cycles after the ISSUE cycle.
- Strobes are never asserted outside ISSUE; `sys_wen` and `sys_ren` are never high together.
- All outputs are registered except `cmd_rdy` and `busy`.

## Test plan
- Write: `cmd_we=1`, `addr=0x00000030`, `wdata=0x12345678`, `sel=0xF`, slave acks 1 cycle after the strobe. Required: `sys_wen` high exactly in C2 with those values; `rsp_vld` in C4 with `rsp_err=0`, `rsp_tmo=0`, `rsp_rdata=0`.
- Read: `addr=0x00000028`, slave returns `0xCAFEBABE` with ack. Required: `sys_ren` one cycle; `rsp_rdata=0xCAFEBABE`, `rsp_err=0`.
- Timeout: slave never acks, `TMO_CYCLES=16`. Required: `rsp_vld` 17 cycles after ISSUE with `rsp_tmo=1`, `rsp_err=1`, `rsp_rdata=0`. An ack injected 2 cycles later produces no extra response.
- Backpressure/full: `rsp_rdy=0`, slave acks promptly, 6 commands offered to addresses 0x00..0x14. Required: 5 accepted (1 in flight plus 4 in FIFO), then `cmd_rdy=0`. After `rsp_rdy=1`, responses and bus strobes occur in address order, and `cmd_rdy` reasserts after the first response handshake.
- Slave error: ack together with `sys_err=1` on a read. Required: `rsp_err=1`, `rsp_tmo=0`, `rsp_rdata` equals the sampled `sys_rdata`.
- Reset mid-WAIT: assert `adc_rst_i` for 1 cycle with 2 commands queued. Required: next cycle all `sys_*`/`rsp_*`/`busy` are 0 and the FIFO is empty; the following ack is ignored and no response is produced.
